// File: rtl/sig_trace_capture_pkg.sv
// sig_trace_capture_pkg: shared states, default sizes and entry width for the trace capture block
package sig_trace_capture_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_e;
    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_STAMP_W = 16;
    localparam int ENTRY_W = DEFAULT_STAMP_W + 32;
    function automatic int entry_width(int stamp_w);
        return stamp_w + 32;
    endfunction
endpackage

// File: rtl/sig_trace_capture_if.sv
// sig_trace_capture_if: read-side handshake and status of the trace capture block
interface sig_trace_capture_if
    import sig_trace_capture_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int STAMP_W = DEFAULT_STAMP_W
);
    logic rd_valid;
    logic rd_ready;
    logic [entry_width(STAMP_W)-1:0] rd_data;
    logic [$clog2(DEPTH):0] count;
    logic overflow;
    logic busy;
    modport master(output rd_valid, rd_data, count, overflow, busy, input rd_ready);
    modport slave(input rd_valid, rd_data, count, overflow, busy, output rd_ready);
endinterface

// File: rtl/sig_trace_capture_fifo.sv
// trace_fifo: circular capture buffer; a push into a full buffer is accepted only alongside a pop
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 48
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic wr_en, rd_en;
    assign empty_o = cnt_q == '0;
    assign full_o = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign dout_o = mem_q[rd_q];
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (rd_en) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    // storage needs no reset; only entries below count are ever read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/sig_trace_capture.sv
// sig_trace_capture: logs stamped {a,b,c,d} samples on change during an armed capture session
module sig_trace_capture
    import sig_trace_capture_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int STAMP_W = DEFAULT_STAMP_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 a,
    input  logic [7:0]                 b,
    input  logic [7:0]                 c,
    input  logic [7:0]                 d,
    input  logic                       arm,
    input  logic                       stop,
    sig_trace_capture_if.master        rd
);
    localparam int EW = entry_width(STAMP_W);
    state_e state_q, state_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [31:0] prev_q, prev_d, sample;
    logic ovf_q, ovf_d;
    logic cap, stamp_max, push, pop, full, empty;
    logic [EW-1:0] dout;
    logic [$clog2(DEPTH):0] cnt;
    assign sample = {a, b, c, d};
    assign cap = state_q == CAPTURE;
    assign stamp_max = &stamp_q;
    assign pop = !empty && rd.rd_ready;
    // stamp is zero only in the first capture cycle, which always logs
    assign push = cap && (stamp_q == '0 || sample != prev_q);
    assign rd.rd_valid = !empty;
    assign rd.rd_data = dout;
    assign rd.count = cnt;
    assign rd.overflow = ovf_q;
    assign rd.busy = cap;
    // session control: arm outside capture restarts the stamp, stop or a saturated stamp ends it
    always_comb begin
        state_d = state_q;
        stamp_d = stamp_q;
        prev_d = prev_q;
        ovf_d = ovf_q;
        if (cap) begin
            state_d = (stop || stamp_max) ? DONE : CAPTURE;
            stamp_d = stamp_max ? stamp_q : stamp_q + STAMP_W'(1);
            prev_d = sample;
            ovf_d = ovf_q || (push && full && !pop);
        end else if (arm) begin
            state_d = CAPTURE;
            stamp_d = '0;
            ovf_d = 1'b0;
        end
    end
    // session state, stamp, change reference and sticky drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stamp_q <= '0;
            prev_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stamp_q <= stamp_d;
            prev_q <= prev_d;
            ovf_q <= ovf_d;
        end
    end
    trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(push),
        .pop_i(pop),
        .din_i({stamp_q, sample}),
        .dout_o(dout),
        .full_o(full),
        .empty_o(empty),
        .count_o(cnt)
    );
endmodule
